// File: rtl/murax_pwm_pkg.sv
// murax_pwm_pkg
// Shared constants for the Murax multi-channel PWM peripheral:
//   - APB register byte offsets (CTRL, PRESCALE, PERIOD, STATUS, DUTY_BASE)
//   - bit positions inside CTRL and STATUS
//   - counting-direction enum used by the timebase
package murax_pwm_pkg;

  localparam int unsigned REG_CTRL      = 32'h00;
  localparam int unsigned REG_PRESCALE  = 32'h04;
  localparam int unsigned REG_PERIOD    = 32'h08;
  localparam int unsigned REG_STATUS    = 32'h0C;
  localparam int unsigned REG_DUTY_BASE = 32'h10;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_CENTER     = 1;
  localparam int CTRL_IRQEN      = 2;
  localparam int CTRL_INVERT_LSB = 8;

  localparam int STATUS_WRAP = 0;
  localparam int STATUS_DIR  = 1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/murax_pwm_timebase.sv
// murax_pwm_timebase
// Shared prescaler + period counter for all PWM channels, with edge- or
// center-aligned counting and update-event generation.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   en            counting enable; while low everything is held at 0 / up
//   center        1 = triangle (up/down) counting, 0 = sawtooth
//   prescale      prescaler terminal value (tick every prescale+1 cycles)
//   period        active period value
//   cnt           current counter value
//   dir           current counting direction
//   update        high in the cycle of a period boundary (shadow reload point)
module murax_pwm_timebase
  import murax_pwm_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 center,
  input  logic [CNT_WIDTH-1:0] prescale,
  input  logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] cnt,
  output dir_e                 dir,
  output logic                 update
);

  logic [CNT_WIDTH-1:0] presc;
  logic                 tick;

  assign tick = en && (presc == prescale);

  // Period boundary: top of the sawtooth in edge mode, bottom of the
  // triangle (on the way down) in center mode. A zero period in center
  // mode parks the counter at 0, so every tick is a boundary.
  always_comb begin
    update = 1'b0;
    if (tick) begin
      if (!center) begin
        update = (cnt == period);
      end else begin
        update = (period == '0) || ((cnt == '0) && (dir == DIR_DOWN));
      end
    end
  end

  // Prescaler and counter. Disabling holds the whole timebase at its
  // start position so the next enable begins a fresh period. The turnaround
  // in center mode happens on the tick that leaves the end value, so both
  // end values are held for exactly one tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      cnt   <= '0;
      dir   <= DIR_UP;
    end else if (!en) begin
      presc <= '0;
      cnt   <= '0;
      dir   <= DIR_UP;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        if (!center) begin
          dir <= DIR_UP;
          cnt <= (cnt == period) ? '0 : cnt + 1'b1;
        end else if (period == '0) begin
          dir <= DIR_UP;
          cnt <= '0;
        end else if (dir == DIR_UP) begin
          if (cnt == period) begin
            dir <= DIR_DOWN;
            cnt <= cnt - 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          if (cnt == '0) begin
            dir <= DIR_UP;
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/murax_pwm_apb.sv
// murax_pwm_apb
// APB3-mapped multi-channel PWM peripheral. Holds the register file, the
// pending/active shadow copies of period and duty, the per-channel
// comparators and the registered output pins.
// Ports:
//   io_mainClk, io_asyncReset   clock, asynchronous active-high reset
//   io_apb_*                    zero-wait-state APB3 slave
//   io_pwm_pins                 registered PWM outputs, one per channel
//   io_interrupt                WRAP flag gated by IRQEN
module murax_pwm_apb
  import murax_pwm_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  io_mainClk,
  input  logic                  io_asyncReset,
  input  logic [ADDR_WIDTH-1:0] io_apb_PADDR,
  input  logic                  io_apb_PSEL,
  input  logic                  io_apb_PENABLE,
  input  logic                  io_apb_PWRITE,
  input  logic [31:0]           io_apb_PWDATA,
  output logic [31:0]           io_apb_PRDATA,
  output logic                  io_apb_PREADY,
  output logic                  io_apb_PSLVERR,
  output logic [CHANNELS-1:0]   io_pwm_pins,
  output logic                  io_interrupt
);

  logic clk;
  logic rst;
  assign clk = io_mainClk;
  assign rst = io_asyncReset;

  logic                 ctrl_en;
  logic                 ctrl_center;
  logic                 ctrl_irqen;
  logic [CHANNELS-1:0]  invert;
  logic [CNT_WIDTH-1:0] prescale;
  logic [CNT_WIDTH-1:0] period_pend;
  logic [CNT_WIDTH-1:0] period_act;
  logic [CNT_WIDTH-1:0] duty_pend [CHANNELS];
  logic [CNT_WIDTH-1:0] duty_act  [CHANNELS];
  logic                 wrap;

  logic [CNT_WIDTH-1:0] cnt;
  dir_e                 dir;
  logic                 update;
  logic [CHANNELS-1:0]  raw;

  logic                 wr;
  logic                 sel_ctrl;
  logic                 sel_prescale;
  logic                 sel_period;
  logic                 sel_status;
  logic [CHANNELS-1:0]  duty_hit;
  logic [CNT_WIDTH-1:0] wdata_cnt;

  // Only the low CNT_WIDTH bits and the CTRL fields are stored.
  logic unused_pwdata;
  assign unused_pwdata = ^io_apb_PWDATA;

  assign io_apb_PREADY  = 1'b1;
  assign io_apb_PSLVERR = 1'b0;
  assign io_interrupt   = wrap & ctrl_irqen;

  assign wr           = io_apb_PSEL & io_apb_PENABLE & io_apb_PWRITE;
  assign sel_ctrl     = (io_apb_PADDR == ADDR_WIDTH'(REG_CTRL));
  assign sel_prescale = (io_apb_PADDR == ADDR_WIDTH'(REG_PRESCALE));
  assign sel_period   = (io_apb_PADDR == ADDR_WIDTH'(REG_PERIOD));
  assign sel_status   = (io_apb_PADDR == ADDR_WIDTH'(REG_STATUS));
  assign wdata_cnt    = io_apb_PWDATA[CNT_WIDTH-1:0];

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      duty_hit[i] = (io_apb_PADDR == ADDR_WIDTH'(REG_DUTY_BASE + 4 * i));
    end
  end

  murax_pwm_timebase #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_timebase (
    .clk     (clk),
    .rst     (rst),
    .en      (ctrl_en),
    .center  (ctrl_center),
    .prescale(prescale),
    .period  (period_act),
    .cnt     (cnt),
    .dir     (dir),
    .update  (update)
  );

  // Software-visible registers. WRAP is sticky; a period boundary in the
  // same cycle as a write-1-to-clear keeps the flag set so no wrap is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_en     <= 1'b0;
      ctrl_center <= 1'b0;
      ctrl_irqen  <= 1'b0;
      invert      <= '0;
      prescale    <= '0;
      period_pend <= '0;
      wrap        <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_pend[i] <= '0;
      end
    end else begin
      if (wr && sel_ctrl) begin
        ctrl_en     <= io_apb_PWDATA[CTRL_EN];
        ctrl_center <= io_apb_PWDATA[CTRL_CENTER];
        ctrl_irqen  <= io_apb_PWDATA[CTRL_IRQEN];
        invert      <= io_apb_PWDATA[CTRL_INVERT_LSB +: CHANNELS];
      end
      if (wr && sel_prescale) begin
        prescale <= wdata_cnt;
      end
      if (wr && sel_period) begin
        period_pend <= wdata_cnt;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr && duty_hit[i]) begin
          duty_pend[i] <= wdata_cnt;
        end
      end
      if (update) begin
        wrap <= 1'b1;
      end else if (wr && sel_status && io_apb_PWDATA[STATUS_WRAP]) begin
        wrap <= 1'b0;
      end
    end
  end

  // Active copies only change at a period boundary so a running waveform
  // never sees a half-applied setting; while disabled they track pending
  // continuously so the first enabled period already uses fresh values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_act <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_act[i] <= '0;
      end
    end else if (!ctrl_en || update) begin
      period_act <= period_pend;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_act[i] <= duty_pend[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      raw[i] = (cnt < duty_act[i]);
    end
  end

  // Registered pins keep the board outputs glitch-free; a disabled channel
  // rests at its inactive level, which is the INVERT bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_pwm_pins <= '0;
    end else begin
      io_pwm_pins <= (ctrl_en ? raw : '0) ^ invert;
    end
  end

  // Combinational read mux; PERIOD and DUTY read back the pending values.
  always_comb begin
    io_apb_PRDATA = '0;
    if (io_apb_PSEL) begin
      if (sel_ctrl) begin
        io_apb_PRDATA[CTRL_EN]                        = ctrl_en;
        io_apb_PRDATA[CTRL_CENTER]                    = ctrl_center;
        io_apb_PRDATA[CTRL_IRQEN]                     = ctrl_irqen;
        io_apb_PRDATA[CTRL_INVERT_LSB +: CHANNELS]    = invert;
      end else if (sel_prescale) begin
        io_apb_PRDATA = 32'(prescale);
      end else if (sel_period) begin
        io_apb_PRDATA = 32'(period_pend);
      end else if (sel_status) begin
        io_apb_PRDATA[STATUS_WRAP] = wrap;
        io_apb_PRDATA[STATUS_DIR]  = (dir == DIR_DOWN);
      end else begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (duty_hit[i]) begin
            io_apb_PRDATA = 32'(duty_pend[i]);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_murax_pwm_apb.sv
// tb_murax_pwm_apb
// Directed plus randomized checks of murax_pwm_apb against an arithmetic
// model of the waveform: the counter value at any cycle is derived from the
// elapsed cycle count, prescale and period (sawtooth or triangle).
module tb_murax_pwm_apb;

  localparam logic [7:0] A_CTRL     = 8'h00;
  localparam logic [7:0] A_PRESCALE = 8'h04;
  localparam logic [7:0] A_PERIOD   = 8'h08;
  localparam logic [7:0] A_STATUS   = 8'h0C;
  localparam logic [7:0] A_DUTY0    = 8'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [3:0]  pins;
  logic        irq;

  murax_pwm_apb #(
    .CHANNELS  (4),
    .CNT_WIDTH (16),
    .ADDR_WIDTH(8)
  ) dut (
    .io_mainClk    (clk),
    .io_asyncReset (rst),
    .io_apb_PADDR  (paddr),
    .io_apb_PSEL   (psel),
    .io_apb_PENABLE(penable),
    .io_apb_PWRITE (pwrite),
    .io_apb_PWDATA (pwdata),
    .io_apb_PRDATA (prdata),
    .io_apb_PREADY (pready),
    .io_apb_PSLVERR(pslverr),
    .io_pwm_pins   (pins),
    .io_interrupt  (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  int         cfgP;
  int         cfgS;
  bit         cfgCenter;
  int         cfgDuty [4];
  logic [3:0] cfgInv;
  int         enCyc;
  int         lastCommit;
  int         lastSample;

  // Counter value during the cycle j cycles after the enabling edge.
  function automatic int cntAt(input int j);
    int t;
    int ph;
    t = j / (cfgS + 1);
    if (!cfgCenter) return t % (cfgP + 1);
    if (cfgP == 0) return 0;
    ph = t % (2 * cfgP);
    return (ph <= cfgP) ? ph : 2 * cfgP - ph;
  endfunction

  // Direction: down on the falling half of the triangle and at its bottom,
  // except at the very start where counting begins upward.
  function automatic logic dirAt(input int j);
    int t;
    int ph;
    t = j / (cfgS + 1);
    if (!cfgCenter || cfgP == 0 || t == 0) return 1'b0;
    ph = t % (2 * cfgP);
    return (ph == 0) || (ph > cfgP);
  endfunction

  // Pins seen k cycles after enable reflect the counter one cycle earlier.
  function automatic logic [3:0] expPins(input int k);
    logic [3:0] e;
    for (int i = 0; i < 4; i++) begin
      e[i] = (cntAt(k - 1) < cfgDuty[i]) ^ cfgInv[i];
    end
    return e;
  endfunction

  function automatic int firstWrap();
    if (!cfgCenter) return (cfgP + 1) * (cfgS + 1);
    if (cfgP == 0) return cfgS + 1;
    return (2 * cfgP + 1) * (cfgS + 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One APB write; returns at the falling edge after the commit edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [31:0] d);
    psel    = 1'b1;
    pwrite  = 1'b1;
    paddr   = a;
    pwdata  = d;
    penable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    penable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lastCommit = cyc;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  task automatic readReg(input logic [7:0] a, output logic [31:0] d);
    psel    = 1'b1;
    pwrite  = 1'b0;
    paddr   = a;
    penable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    penable = 1'b1;
    #1;
    d = prdata;
    lastSample = cyc;
    @(posedge clk);
    @(negedge clk);
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  task automatic checkPinsFor(input int n, input string tag, input bit withIrq);
    int k;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      k = cyc - enCyc;
      checkOutput(tag, 32'(pins), 32'(expPins(k)));
      if (withIrq) checkOutput({tag, "_irq"}, 32'(irq), 32'(k >= firstWrap()));
    end
  endtask

  // Waits (bounded) until the cycle offset from enable, plus 'ahead',
  // reaches the wanted phase of the period.
  task automatic waitPhase(input int md, input int want, input int ahead);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 64 && !found; n++) begin
      if (((cyc + ahead - enCyc) % md) == want) found = 1'b1;
      else @(negedge clk);
    end
    checkOutput("wait_phase", 32'(found), 32'd1);
  endtask

  task automatic configure(input int p, input int s, input bit c,
                           input int d0, input int d1, input int d2, input int d3,
                           input logic [3:0] inv);
    applyStimulus(A_CTRL, 32'd0);
    applyStimulus(A_STATUS, 32'd1);
    applyStimulus(A_PRESCALE, 32'(s));
    applyStimulus(A_PERIOD, 32'(p));
    applyStimulus(A_DUTY0 + 8'h00, 32'(d0));
    applyStimulus(A_DUTY0 + 8'h04, 32'(d1));
    applyStimulus(A_DUTY0 + 8'h08, 32'(d2));
    applyStimulus(A_DUTY0 + 8'h0C, 32'(d3));
    cfgP       = p;
    cfgS       = s;
    cfgCenter  = c;
    cfgDuty[0] = d0;
    cfgDuty[1] = d1;
    cfgDuty[2] = d2;
    cfgDuty[3] = d3;
    cfgInv     = inv;
  endtask

  task automatic startRun(input bit irqen);
    logic [31:0] v;
    v       = '0;
    v[0]    = 1'b1;
    v[1]    = cfgCenter;
    v[2]    = irqen;
    v[11:8] = cfgInv;
    applyStimulus(A_CTRL, v);
    enCyc = lastCommit;
  endtask

  task automatic checkAllZero(input string tag);
    logic [31:0] d;
    logic [7:0]  addrs [8];
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};
    for (int i = 0; i < 8; i++) begin
      readReg(addrs[i], d);
      checkOutput(tag, d, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  inv;
    int          jw;
    int          bnd;
    int          k;
    int          p;
    int          s;

    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_pins", 32'(pins), 32'd0);
    checkOutput("reset_irq", 32'(irq), 32'd0);
    checkOutput("reset_prdata", prdata, 32'd0);
    checkOutput("reset_pready", 32'(pready), 32'd1);
    checkOutput("reset_pslverr", 32'(pslverr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkAllZero("reset_regs");

    // Register access, truncation and unmapped addresses
    applyStimulus(A_PRESCALE, 32'hABCD_1234);
    readReg(A_PRESCALE, d);
    checkOutput("prescale_trunc", d, 32'h0000_1234);
    applyStimulus(8'h40, 32'hFFFF_FFFF);
    readReg(8'h40, d);
    checkOutput("unmapped_read", d, 32'd0);
    readReg(A_CTRL, d);
    checkOutput("unmapped_write", d, 32'd0);
    applyStimulus(A_CTRL, 32'hFFFF_FA06);
    readReg(A_CTRL, d);
    checkOutput("ctrl_readback", d, 32'h0000_0A06);
    paddr = A_CTRL;
    #1;
    checkOutput("prdata_idle", prdata, 32'd0);

    // Edge-aligned basic waveform with interrupt
    $display("[TB] edge basic");
    configure(9, 0, 0, 3, 0, 0, 0, 4'h0);
    startRun(1'b1);
    checkPinsFor(30, "edge_basic", 1'b1);

    // Duty change mid-period lands at the next boundary
    waitPhase(10, 4, 2);
    applyStimulus(A_DUTY0, 32'd7);
    jw  = lastCommit - enCyc;
    bnd = (jw / 10 + 1) * 10;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      k = cyc - enCyc;
      cfgDuty[0] = (k - 1 >= bnd) ? 7 : 3;
      checkOutput("shadow", 32'(pins), 32'(expPins(k)));
    end
    cfgDuty[0] = 7;

    // Interrupt: W1C racing a wrap, then a clean clear
    waitPhase(10, 0, 2);
    applyStimulus(A_STATUS, 32'd1);
    checkOutput("w1c_vs_wrap", 32'(irq), 32'd1);
    waitPhase(10, 5, 2);
    applyStimulus(A_STATUS, 32'd1);
    checkOutput("w1c_clean", 32'(irq), 32'd0);
    readReg(A_STATUS, d);
    checkOutput("status_cleared", d, 32'd0);
    waitPhase(10, 1, 0);
    checkOutput("irq_rearm", 32'(irq), 32'd1);

    // Center-aligned waveform and DIR readback
    $display("[TB] center mode");
    configure(4, 1, 1, 0, 2, 0, 0, 4'h0);
    startRun(1'b0);
    checkPinsFor(32, "center", 1'b0);
    for (int r = 0; r < 6; r++) begin
      readReg(A_STATUS, d);
      k = lastSample - enCyc;
      checkOutput("center_status", d, {30'd0, dirAt(k), k >= firstWrap()});
    end

    // Extremes and polarity
    $display("[TB] extremes");
    configure(9, 0, 0, 5, 3, 0, 16'hFFFF, 4'b0100);
    startRun(1'b0);
    checkPinsFor(20, "extremes", 1'b0);
    inv = 4'($urandom_range(0, 15));
    applyStimulus(A_CTRL, {20'd0, inv, 8'd0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("disabled_pins", 32'(pins), 32'(inv));
    end

    // Randomized edge and center runs
    $display("[TB] random runs");
    for (int it = 0; it < 5; it++) begin
      p = (it < 3) ? $urandom_range(1, 12) : $urandom_range(1, 6);
      s = $urandom_range(0, 3);
      configure(p, s, it >= 3,
                $urandom_range(0, p + 2), $urandom_range(0, p + 2),
                $urandom_range(0, p + 2), $urandom_range(0, p + 2),
                4'($urandom_range(0, 15)));
      startRun(1'b1);
      checkPinsFor(2 * firstWrap() + 4, (it < 3) ? "rand_edge" : "rand_center", 1'b1);
    end

    // Asynchronous reset in the middle of a run
    $display("[TB] reset mid-run");
    configure(5, 2, 0, 0, 0, 0, 0, 4'hF);
    startRun(1'b1);
    checkPinsFor(20, "pre_reset", 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_pins", 32'(pins), 32'd0);
    checkOutput("async_reset_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_pins", 32'(pins), 32'd0);
    checkAllZero("post_reset_regs");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
